bf_tape_ctrl: RTL and testbench

//  Sequences Brainfuck tape operations (+ - > <) onto a single shared inc_dec unit.

---
 rtl/bf_tape_if.sv | 27 ++
 rtl/bf_tape_ctrl.sv | 99 +++++++++
 tb/tb_bf_tape_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bf_tape_if.sv
// Op-stream and tape-RAM signal bundle for the Brainfuck tape controller.
// master = decoder/RAM side, slave = controller side.
interface bf_tape_if #(
  parameter int unsigned c_data_width = 8,
  parameter int unsigned c_addr_width = 12
);
  logic                    i_valid;
  logic                    o_ready;
  logic [1:0]              i_op;
  logic [c_addr_width-1:0] o_ptr;
  logic [c_addr_width-1:0] o_mem_addr;
  logic                    o_mem_re;
  logic [c_data_width-1:0] i_mem_rdata;
  logic                    o_mem_we;
  logic [c_data_width-1:0] o_mem_wdata;
  logic                    o_done;

  modport master (
    output i_valid, i_op, i_mem_rdata,
    input  o_ready, o_ptr, o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata, o_done
  );

  modport slave (
    input  i_valid, i_op, i_mem_rdata,
    output o_ready, o_ptr, o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata, o_done
  );
endinterface

// File: rtl/bf_tape_ctrl.sv
// Brainfuck tape controller: pointer moves and cell read-modify-write
// sequenced onto one shared incrementer/decrementer.

module bf_inc_dec #(
  parameter int unsigned c_width = 12
) (
  input  logic [c_width-1:0] operand,
  input  logic               dec,
  output logic [c_width-1:0] result_c
);
  assign result_c = dec ? operand - c_width'(1) : operand + c_width'(1);
endmodule

module bf_tape_ctrl #(
  parameter int unsigned c_data_width = 8,
  parameter int unsigned c_addr_width = 12
) (
  input  logic    i_clk,
  input  logic    i_rst,
  bf_tape_if.slave bus
);
  localparam int unsigned DW = c_data_width;
  localparam int unsigned AW = c_addr_width;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic            dec_q;
  logic            mem_re;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;
  logic            done;

  logic [AW-1:0]   operand;
  logic            dec_sel;
  logic [AW-1:0]   result;

  // The single arithmetic unit serves the pointer in IDLE and the cell in WAIT.
  assign operand = (state == S_WAIT) ? AW'(bus.i_mem_rdata) : ptr;
  assign dec_sel = (state == S_IDLE) ? bus.i_op[0] : dec_q;

  bf_inc_dec #(.c_width(AW)) u_inc_dec (
    .operand  (operand),
    .dec      (dec_sel),
    .result_c (result)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      dec_q     <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_valid) begin
            if (bus.i_op[1]) begin
              ptr  <= result;
              done <= 1'b1;
            end else begin
              dec_q  <= bus.i_op[0];
              mem_re <= 1'b1;
              state  <= S_RD;
            end
          end
        end
        S_RD: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          mem_wdata <= result[DW-1:0];
          mem_we    <= 1'b1;
          done      <= 1'b1;
          state     <= S_WR;
        end
        S_WR: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready     = (state == S_IDLE);
  assign bus.o_ptr       = ptr;
  assign bus.o_mem_addr  = ptr;
  assign bus.o_mem_re    = mem_re;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_done      = done;
endmodule

// File: tb/tb_bf_tape_ctrl.sv
// Directed and random checks of bf_tape_ctrl against a behavioural tape RAM
// and a golden pointer/tape model.
module tb_bf_tape_ctrl;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bf_tape_if #(.c_data_width(DW), .c_addr_width(AW)) bus ();

  bf_tape_ctrl #(.c_data_width(DW), .c_addr_width(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] gold [DEPTH];
  logic [AW-1:0] gptr;

  int checks        = 0;
  int failures      = 0;
  int we_count      = 0;
  int overlap_count = 0;

  // Synchronous tape RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.o_mem_re) bus.i_mem_rdata <= mem[bus.o_mem_addr];
    if (bus.o_mem_we) begin
      mem[bus.o_mem_addr] = bus.o_mem_wdata;
      we_count++;
    end
    if (bus.o_mem_re && bus.o_mem_we) overlap_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0;
    bus.i_op    = 2'b00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present one op, wait for its transfer and its done pulse.
  task automatic send(input logic [1:0] op);
    logic acc;
    logic got;
    acc = 1'b0;
    got = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    for (int n = 0; n < 20 && !acc; n++) begin
      acc = bus.o_ready;
      tick();
    end
    bus.i_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    for (int n = 0; n < 8 && !got; n++) begin
      if (bus.o_done) got = 1'b1;
      else tick();
    end
    if (!got) check("done_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    int base;
    int mism;
    bus.i_valid     = 1'b0;
    bus.i_op        = 2'b00;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

    // Reset values
    tick();
    check("rst_ptr",   32'(bus.o_ptr),       32'd0);
    check("rst_re",    32'(bus.o_mem_re),    32'd0);
    check("rst_we",    32'(bus.o_mem_we),    32'd0);
    check("rst_wdata", 32'(bus.o_mem_wdata), 32'd0);
    check("rst_done",  32'(bus.o_done),      32'd0);
    check("rst_ready", 32'(bus.o_ready),     32'd1);

    // 1: '>' x3 back to back
    do_reset();
    bus.i_valid = 1'b1;
    bus.i_op    = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t1_ptr",   32'(bus.o_ptr),   32'(i));
      check("t1_done",  32'(bus.o_done),  32'd1);
      check("t1_ready", 32'(bus.o_ready), 32'd1);
    end
    bus.i_valid = 1'b0;
    tick();
    check("t1_done_end", 32'(bus.o_done), 32'd0);
    check("t1_ptr_end",  32'(bus.o_ptr),  32'd3);

    // 2: pointer wrap both ways
    do_reset();
    bus.i_valid = 1'b1;
    bus.i_op    = 2'b11;
    tick();
    check("t2_ptr_wrap_dn", 32'(bus.o_ptr), 32'hFFF);
    bus.i_op = 2'b10;
    tick();
    check("t2_ptr_wrap_up", 32'(bus.o_ptr), 32'h000);
    bus.i_valid = 1'b0;

    // 3: '+' on 0xFF at ptr 5, cycle-exact
    do_reset();
    bus.i_valid = 1'b1;
    bus.i_op    = 2'b10;
    repeat (5) tick();
    bus.i_valid = 1'b0;
    check("t3_ptr5", 32'(bus.o_ptr), 32'd5);
    mem[5] = 8'hFF;
    bus.i_valid = 1'b1;
    bus.i_op    = 2'b00;
    tick();
    bus.i_valid = 1'b0;
    check("t3_c1_re",    32'(bus.o_mem_re),   32'd1);
    check("t3_c1_addr",  32'(bus.o_mem_addr), 32'd5);
    check("t3_c1_ready", 32'(bus.o_ready),    32'd0);
    check("t3_c1_we",    32'(bus.o_mem_we),   32'd0);
    tick();
    check("t3_c2_re",    32'(bus.o_mem_re),   32'd0);
    check("t3_c2_we",    32'(bus.o_mem_we),   32'd0);
    check("t3_c2_ready", 32'(bus.o_ready),    32'd0);
    tick();
    check("t3_c3_we",    32'(bus.o_mem_we),    32'd1);
    check("t3_c3_re",    32'(bus.o_mem_re),    32'd0);
    check("t3_c3_addr",  32'(bus.o_mem_addr),  32'd5);
    check("t3_c3_wdata", 32'(bus.o_mem_wdata), 32'h00);
    check("t3_c3_done",  32'(bus.o_done),      32'd1);
    check("t3_c3_ready", 32'(bus.o_ready),     32'd0);
    tick();
    check("t3_c4_ready", 32'(bus.o_ready), 32'd1);
    check("t3_c4_we",    32'(bus.o_mem_we), 32'd0);
    check("t3_c4_done",  32'(bus.o_done),   32'd0);
    check("t3_mem5",     32'(mem[5]),       32'h00);

    // 4: '-' on 0x00, then '-' with valid held through busy cycles
    mem[5] = 8'h00;
    bus.i_valid = 1'b1;
    bus.i_op    = 2'b01;
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();
    check("t4_we",    32'(bus.o_mem_we),    32'd1);
    check("t4_wdata", 32'(bus.o_mem_wdata), 32'hFF);
    tick();
    base = we_count;
    bus.i_valid = 1'b1;
    bus.i_op    = 2'b01;
    tick();
    tick();
    tick();
    check("t4_hold_we",    32'(bus.o_mem_we),    32'd1);
    check("t4_hold_wdata", 32'(bus.o_mem_wdata), 32'hFE);
    bus.i_valid = 1'b0;
    repeat (5) tick();
    check("t4_one_accept", 32'(we_count - base), 32'd1);
    check("t4_mem5",       32'(mem[5]),          32'hFE);
    check("t4_ptr",        32'(bus.o_ptr),       32'd5);

    // 5: reset during WAIT of a '+'
    do_reset();
    bus.i_valid = 1'b1;
    bus.i_op    = 2'b10;
    repeat (3) tick();
    bus.i_valid = 1'b0;
    mem[3] = 8'h07;
    base = we_count;
    bus.i_valid = 1'b1;
    bus.i_op    = 2'b00;
    tick();
    bus.i_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("t5_we",    32'(bus.o_mem_we), 32'd0);
    check("t5_re",    32'(bus.o_mem_re), 32'd0);
    check("t5_ptr",   32'(bus.o_ptr),    32'd0);
    check("t5_done",  32'(bus.o_done),   32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("t5_no_write", 32'(we_count - base), 32'd0);
    check("t5_mem3",     32'(mem[3]),          32'h07);
    check("t5_ready",    32'(bus.o_ready),     32'd1);
    check("t5_ptr_rel",  32'(bus.o_ptr),       32'd0);

    // 6: random op stream vs golden model
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]  = DW'($urandom);
      gold[i] = mem[i];
    end
    gptr = '0;
    for (int k = 0; k < 1000; k++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      send(op);
      case (op)
        2'b00: gold[gptr] = gold[gptr] + DW'(1);
        2'b01: gold[gptr] = gold[gptr] - DW'(1);
        2'b10: gptr = gptr + AW'(1);
        default: gptr = gptr - AW'(1);
      endcase
    end
    repeat (4) tick();
    check("t6_ptr", 32'(bus.o_ptr), 32'(gptr));
    mism = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== gold[i]) mism++;
    check("t6_tape_mismatches", 32'(mism),          32'd0);
    check("t6_re_we_overlap",   32'(overlap_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
